// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-port memory arbiter.
// No logic; no latency; no backpressure.
// Imported by the interface, the picker and the top level.
package mem_arb_pkg;

    localparam int MEM_ARB_DATA_W = 16;
    localparam int MEM_ARB_ADDR_W = 2;
    localparam int MEM_ARB_NPORT  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of both requester ports plus the memory pins seen by mem_arb.
// No logic; no latency; requesters hold req until ack (level handshake).
// master = arbiter side, slave = requesters and memory.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = MEM_ARB_DATA_W,
    parameter int ADDR_W = MEM_ARB_ADDR_W
) ();

    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic              m_sel;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, m_rdata,
        output ack0, ack1, rdata0, rdata1, m_sel, m_wr, m_addr, m_wdata
    );

    modport slave (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, m_rdata,
        input  ack0, ack1, rdata0, rdata1, m_sel, m_wr, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between the two request lines (MEM_ARB_RR_EN: round robin).
// Purely combinational, zero latency.
// No backpressure; losers simply keep requesting.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [MEM_ARB_NPORT-1:0] req,
`ifdef MEM_ARB_RR_EN
    input  logic                     last_vld,
    input  logic                     last_gnt,
`endif
    output logic                     win,
    output logic                     win_vld
);

    always_comb begin
        win_vld = |req;
        win     = 1'b0;
        if (req == 2'b10) begin
            win = 1'b1;
        end
`ifdef MEM_ARB_RR_EN
        // Until something has been granted, port 0 takes the first conflict.
        else if (req == 2'b11) begin
            win = last_vld ? ~last_gnt : 1'b0;
        end
`endif
    end

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter/sequencer for the 4x16 register memory (MEM_ARB_RR_EN selects round robin).
// Latency: request sampled at edge N -> m_sel in cycle N+1 -> ack in cycle N+2; one transaction per 3 cycles.
// Backpressure: the loser holds req high and is served in a later transaction.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = MEM_ARB_DATA_W,
    parameter int ADDR_W = MEM_ARB_ADDR_W
) (
    input  logic         clk,
    input  logic         rstn,
    mem_arb_if.master    bus
);

    mem_arb_state_t    state_q, state_d;
    logic              gnt_q, gnt_d;

    logic              m_sel_q, m_sel_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rd_dat;

    logic [MEM_ARB_NPORT-1:0] req_vec;
    logic                     win;
    logic                     win_vld;

`ifdef MEM_ARB_RR_EN
    logic rr_q, rr_d;
    logic rr_vld_q, rr_vld_d;
`endif

    assign req_vec = {bus.req1, bus.req0};

    mem_arb_pick u_pick (
        .req      (req_vec),
`ifdef MEM_ARB_RR_EN
        .last_vld (rr_vld_q),
        .last_gnt (rr_q),
`endif
        .win      (win),
        .win_vld  (win_vld)
    );

    // Memory drives 0 on writes anyway; forcing it keeps write acks clean.
    assign rd_dat = m_wr_q ? '0 : bus.m_rdata;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        m_sel_d   = 1'b0;
        m_wr_d    = 1'b0;
        m_addr_d  = '0;
        m_wdata_d = '0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = '0;
        rdata1_d  = '0;
`ifdef MEM_ARB_RR_EN
        rr_d      = rr_q;
        rr_vld_d  = rr_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d   = ACCESS;
                    gnt_d     = win;
                    m_sel_d   = 1'b1;
                    m_wr_d    = win ? bus.wr1    : bus.wr0;
                    m_addr_d  = win ? bus.addr1  : bus.addr0;
                    m_wdata_d = win ? bus.wdata1 : bus.wdata0;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (gnt_q) begin
                    ack1_d   = 1'b1;
                    rdata1_d = rd_dat;
                end else begin
                    ack0_d   = 1'b1;
                    rdata0_d = rd_dat;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef MEM_ARB_RR_EN
                rr_d     = gnt_q;
                rr_vld_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            m_sel_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            m_sel_q   <= m_sel_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q     <= 1'b0;
            rr_vld_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            rr_vld_q <= rr_vld_d;
        end
    end
`endif

    assign bus.m_sel   = m_sel_q;
    assign bus.m_wr    = m_wr_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter and sequencer for the 4x16 register memory (`mem`). It accepts read and write requests on two independent request/acknowledge ports and picks one winner per transaction. It drives the memory's `sel`/`wr`/`addr`/`wdata` pins for exactly one cycle, then returns read data and a single-cycle acknowledge to the winner. It sits between the memory and its two bus-side clients, and it is the only master of the memory.

## Interface
Parameters:
- `DATA_W`, 16, data width; must match the memory's `wdata`/`rdata` width.
- `ADDR_W`, 2, address width; must match the memory's `addr` width.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  request from port n; level, held until `ackn`.
- `wr0`, `wr1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  ADDR_W  word address.
- `wdata0`, `wdata1`  in  DATA_W  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DATA_W  read result; valid in the `ackn` cycle.
- `m_sel`  out  1  memory select.
- `m_wr`  out  1  memory write enable.
- `m_addr`  out  ADDR_W  memory address.
- `m_wdata`  out  DATA_W  memory write data.
- `m_rdata`  in  DATA_W  memory read data. The memory drives it combinationally while `m_sel & ~m_wr`, and drives 0 otherwise.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If `req0` or `req1` is high, pick a winner (see Configuration).
  - Latch the winner's `wr`/`addr`/`wdata` and its port index `gnt_q`, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS: drive `m_sel` = 1, `m_wr` = latched wr, `m_addr`/`m_wdata` = latched values for exactly this cycle.
  - On the closing edge of a read, capture `m_rdata` into `rdata_q`.
  - On the closing edge of a write, set `rdata_q` = 0.
  - Go to RESP.
- RESP: drive `ack[gnt_q]` = 1 and `rdata[gnt_q]` = `rdata_q`, then go to IDLE. The round-robin pointer updates on this edge.
- Outside RESP, `rdata0`/`rdata1` are 0. The losing port never sees `ack` or data.
- Requester protocol:
  - Hold `req`/`wr`/`addr`/`wdata` stable until `ack` is seen.
  - Drop `req` in the cycle after `ack`, or keep it high to issue a new transaction.
- Request withdrawn before `ack`: protocol violation. The latched transaction still completes and `ack` still pulses.
- Simultaneous `req0` and `req1` in IDLE: exactly one wins. The loser keeps `req` high and is served in the next transaction.
- Outside ACCESS, `m_sel`, `m_wr`, `m_addr` and `m_wdata` are 0. The memory therefore holds its contents and its `rdata` is 0.

## Timing
- All outputs are registered. No combinational path exists from any `reqn` to any output.
- Reset values: `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `m_sel` = `m_wr` = 0, `m_addr` = `m_wdata` = 0. State = IDLE, round-robin pointer = 0.
- Latency: `req` sampled high in IDLE at edge N gives `m_sel` high in cycle N+1 and `ack` in cycle N+2.
- Throughput: one transaction per 3 cycles, with no idle cycle between back-to-back transactions.
- A write lands in the memory on the edge that ends ACCESS. A read issued to the same address on the next transaction returns the new data.
- Reset asserted mid-transaction (ACCESS or RESP): all outputs go to 0 immediately and the transaction is dropped with no `ack`.
  - The memory's own synchronous reset then clears its contents.
  - After `rstn` deasserts, the first IDLE sample happens on the next rising edge.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a conflict, the port other than the one last granted wins.
  - The 1-bit pointer is updated in RESP to the last granted index.
  - After reset, port 0 wins the first conflict.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 0 always beats port 1. The pointer register is not built.
- Non-conflicting requests behave identically in both builds.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enumeration `mem_arb_state_t` (IDLE, ACCESS, RESP);
  - constants `MEM_ARB_DATA_W` = 16, `MEM_ARB_ADDR_W` = 2;
  - the port count `MEM_ARB_NPORT` = 2.
- One sub-module, `mem_arb_pick`:
  - purely combinational;
  - inputs: request vector and last-grant pointer;
  - outputs: winner index and a valid flag;
  - contains the `MEM_ARB_RR_EN` selection.
- Top level: FSM, latch registers, output registers.

## Test plan
- Single write then read, port 0:
  - write addr 2, data 0xBEEF: `m_sel`/`m_wr` high for 1 cycle, `ack0` 2 cycles after the request is sampled;
  - read addr 2: `rdata0` = 0xBEEF in the `ack0` cycle, `ack1` never asserted.
- Simultaneous requests:
  - `req0` and `req1` both reading addr 1 after reset: port 0 is acked first, port 1 three cycles later;
  - both return the same value.
- Sustained conflict with `MEM_ARB_RR_EN` defined: grants alternate 0,1,0,1 over 4 transactions.
- Sustained conflict with `MEM_ARB_RR_EN` undefined: port 0 is granted every transaction while `req0` stays high.
- Reset mid-transaction:
  - pull `rstn` low in ACCESS of a write of 0x1234 to addr 3;
  - no `ack` is produced and all outputs read 0 during reset;
  - a later read of addr 3 returns 0.
- Idle bus: with no requests for 10 cycles, `m_sel` stays 0 and `rdata0`/`rdata1` stay 0.
